// File: rtl/reg_seq_pkg.sv
// Shared constants and types for the register/databus sequencer.
package reg_seq_pkg;

   localparam int FLAG_A_IN   = 0;
   localparam int FLAG_RAMI   = 8;
   localparam int FLAG_MARI   = 9;
   localparam int FLAG_MPAGEI = 10;
   localparam int FLAG_OI     = 11;
   localparam int FLAG_A_OUT  = 12;
   localparam int FLAG_ALUO   = 20;
   localparam int FLAG_ROMO   = 21;
   localparam int FLAG_RAMO   = 22;
   localparam int FLAG_JMPO   = 23;
   localparam int FLAG_IO     = 24;

   localparam logic [3:0] DST_RAMI   = 4'h8;
   localparam logic [3:0] DST_MARI   = 4'h9;
   localparam logic [3:0] DST_MPAGEI = 4'hA;
   localparam logic [3:0] DST_OI     = 4'hB;
   localparam logic [3:0] SRC_ROMO   = 4'h8;
   localparam logic [3:0] SRC_RAMO   = 4'h9;
   localparam logic [3:0] SRC_IO     = 4'hA;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_MOV = 4'h1,
      OP_ALU = 4'h2,
      OP_LDI = 4'h3,
      OP_JMP = 4'h4,
      OP_JZ  = 4'h5,
      OP_OUT = 4'h6,
      OP_HLT = 4'hF
   } op_e;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_IMM,
      ST_HALT
   } state_e;

   typedef enum logic [1:0] {
      WAIT_NONE,
      WAIT_RAM,
      WAIT_ROM
   } wait_e;

endpackage

// File: rtl/reg_seq_decode.sv
// Combinational decode of an instruction word into a control mask and legality.
module reg_seq_decode
   import reg_seq_pkg::*;
#(
   parameter int FLAGS_LEN = 25
) (
   input  logic [3:0]           op,
   input  logic [3:0]           dst,
   input  logic [3:0]           src,
   output logic [FLAGS_LEN-1:0] mask,
   output logic                 bad,
   output logic                 imm,
   output logic                 exec,
   output logic                 stop,
   output wait_e                src_wait
);

   logic [FLAGS_LEN-1:0] in_mask;
   logic [FLAGS_LEN-1:0] out_mask;
   logic                 in_ok;
   logic                 out_ok;
   wait_e                src_kind;

   always_comb begin
      in_mask  = '0;
      out_mask = '0;
      in_ok    = (dst <= DST_OI);
      out_ok   = 1'b1;
      src_kind = WAIT_NONE;
      // dst codes 0-B coincide with their input-flag bit index
      if (in_ok) in_mask = FLAGS_LEN'(1) << dst;
      if (src < 4'd8) begin
         out_mask = FLAGS_LEN'(1) << (FLAG_A_OUT + 32'(src));
      end else begin
         case (src)
            SRC_ROMO: begin
               out_mask[FLAG_ROMO] = 1'b1;
               src_kind            = WAIT_ROM;
            end
            SRC_RAMO: begin
               out_mask[FLAG_RAMO] = 1'b1;
               src_kind            = WAIT_RAM;
            end
            SRC_IO:  out_mask[FLAG_IO] = 1'b1;
            default: out_ok = 1'b0;
         endcase
      end
   end

   always_comb begin
      mask     = '0;
      bad      = 1'b0;
      imm      = 1'b0;
      exec     = 1'b0;
      stop     = 1'b0;
      src_wait = WAIT_NONE;
      case (op)
         OP_NOP: ;
         OP_MOV: begin
            mask     = in_mask | out_mask;
            bad      = !(in_ok && out_ok);
            exec     = 1'b1;
            src_wait = src_kind;
         end
         OP_ALU: begin
            mask            = in_mask | out_mask;
            mask[FLAG_ALUO] = 1'b1;
            bad             = dst[3] | src[3];
            exec            = 1'b1;
         end
         OP_LDI: begin
            mask            = in_mask;
            mask[FLAG_ROMO] = 1'b1;
            bad             = !in_ok;
            imm             = 1'b1;
         end
         OP_JMP, OP_JZ: begin
            mask[FLAG_JMPO] = 1'b1;
            imm             = 1'b1;
         end
         OP_OUT: begin
            mask          = out_mask;
            mask[FLAG_OI] = 1'b1;
            bad           = !out_ok;
            exec          = 1'b1;
            src_wait      = src_kind;
         end
         OP_HLT:  stop = 1'b1;
         default: bad  = 1'b1;
      endcase
   end

endmodule

// File: rtl/reg_sequencer.sv
// Fetch/decode/execute controller: owns pc, ir and zflag, drives flags/write_en.
module reg_sequencer
   import reg_seq_pkg::*;
#(
   parameter int FLAGS_LEN = 25,
   parameter int PC_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 run_en,
   output logic [PC_W-1:0]      rom_addr,
   output logic                 rom_req,
   input  logic                 rom_valid,
   input  logic [15:0]          rom,
   input  logic                 ram_valid,
   input  logic                 alu_zero,
   output logic [3:0]           alu_op,
   output logic [FLAGS_LEN-1:0] flags,
   output logic                 write_en,
   output logic [PC_W-1:0]      pc,
   output logic                 halted,
   output logic                 illegal
);

   state_e               state;
   wait_e                wait_q;
   logic [15:0]          ir;
   logic                 zflag;
   logic                 we_q;
   logic [3:0]           op_code;
   logic [FLAGS_LEN-1:0] dec_mask;
   logic                 dec_bad;
   logic                 dec_imm;
   logic                 dec_exec;
   logic                 dec_stop;
   wait_e                dec_wait;
   logic                 exec_done;

   assign op_code  = ir[15:12];
   assign alu_op   = ir[3:0];
   assign rom_addr = pc;

   reg_seq_decode #(.FLAGS_LEN(FLAGS_LEN)) u_decode (
      .op       (ir[15:12]),
      .dst      (ir[11:8]),
      .src      (ir[7:4]),
      .mask     (dec_mask),
      .bad      (dec_bad),
      .imm      (dec_imm),
      .exec     (dec_exec),
      .stop     (dec_stop),
      .src_wait (dec_wait)
   );

   assign rom_req = rst_n && ((state == ST_FETCH && run_en) || state == ST_IMM ||
                              (state == ST_EXEC && wait_q == WAIT_ROM));

   // Sources fed from RAM/ROM keep flags on the bus and strobe write_en in the data-valid cycle.
   assign exec_done = (wait_q == WAIT_NONE) || (wait_q == WAIT_RAM && ram_valid) ||
                      (wait_q == WAIT_ROM && rom_valid);
   assign write_en  = we_q || (state == ST_EXEC && wait_q != WAIT_NONE && exec_done);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_FETCH;
         wait_q  <= WAIT_NONE;
         pc      <= '0;
         ir      <= '0;
         zflag   <= 1'b0;
         flags   <= '0;
         we_q    <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (run_en && rom_valid) begin
                  ir    <= rom;
                  pc    <= pc + PC_W'(1);
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_bad) begin
                  illegal <= 1'b1;
                  halted  <= 1'b1;
                  state   <= ST_HALT;
               end else if (dec_stop) begin
                  halted <= 1'b1;
                  state  <= ST_HALT;
               end else if (dec_imm) begin
                  state <= ST_IMM;
               end else if (dec_exec) begin
                  flags  <= dec_mask;
                  we_q   <= (dec_wait == WAIT_NONE);
                  wait_q <= dec_wait;
                  state  <= ST_EXEC;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_IMM: begin
               if (rom_valid) begin
                  wait_q <= WAIT_NONE;
                  state  <= ST_EXEC;
                  case (op_code)
                     OP_LDI: begin
                        flags <= dec_mask;
                        we_q  <= 1'b1;
                        pc    <= pc + PC_W'(1);
                     end
                     OP_JZ: begin
                        if (zflag) begin
                           flags <= dec_mask;
                           pc    <= PC_W'(rom);
                        end else begin
                           pc <= pc + PC_W'(1);
                        end
                     end
                     default: begin
                        flags <= dec_mask;
                        pc    <= PC_W'(rom);
                     end
                  endcase
               end
            end
            ST_EXEC: begin
               if (exec_done) begin
                  flags  <= '0;
                  we_q   <= 1'b0;
                  wait_q <= WAIT_NONE;
                  state  <= ST_FETCH;
                  if (op_code == OP_ALU) zflag <= alu_zero;
                  if (wait_q == WAIT_ROM) pc <= pc + PC_W'(1);
               end
            end
            ST_HALT: ;
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed and randomized checks of reg_sequencer against an instruction-level model.
module tb_reg_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run_en = 1'b0;
   logic        rom_valid = 1'b0;
   logic        ram_valid = 1'b0;
   logic        alu_zero = 1'b0;
   logic [15:0] rom = 16'h0000;
   logic [15:0] rom_addr;
   logic [15:0] pc;
   logic        rom_req;
   logic        write_en;
   logic        halted;
   logic        illegal;
   logic [3:0]  alu_op;
   logic [24:0] flags;

   logic [15:0] mem [65536];
   int          checks = 0;
   int          errors = 0;
   int unsigned lat_min = 0, lat_max = 0, rlat_min = 0, rlat_max = 0;
   int          az_force = 0;
   bit          mon_on = 1'b0;
   bit          rnd_run = 1'b0;
   logic [25:0] obs_q[$];
   logic [25:0] exp_q[$];

   always #5 clk = ~clk;

   reg_sequencer #(.FLAGS_LEN(25), .PC_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_en    (run_en),
      .rom_addr  (rom_addr),
      .rom_req   (rom_req),
      .rom_valid (rom_valid),
      .rom       (rom),
      .ram_valid (ram_valid),
      .alu_zero  (alu_zero),
      .alu_op    (alu_op),
      .flags     (flags),
      .write_en  (write_en),
      .pc        (pc),
      .halted    (halted),
      .illegal   (illegal)
   );

   // ROM/RAM responders with per-request latency; alu_zero from parity unless forced
   initial begin : responder
      int unsigned cnt, cur, rcnt, rcur;
      cnt = 0; cur = 0; rcnt = 0; rcur = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            cnt = 0; rcnt = 0; rom_valid = 1'b0; ram_valid = 1'b0;
         end else begin
            if (rom_req) begin
               if (cnt == 0) cur = $urandom_range(lat_max, lat_min);
               if (cnt >= cur) begin
                  rom_valid = 1'b1; rom = mem[rom_addr]; cnt = 0;
               end else begin
                  rom_valid = 1'b0; rom = 16'hDEAD; cnt++;
               end
            end else begin
               rom_valid = 1'b0; cnt = 0;
            end
            if (flags[22]) begin
               if (rcnt == 0) rcur = $urandom_range(rlat_max, rlat_min);
               if (rcnt >= rcur) begin
                  ram_valid = 1'b1; rcnt = 0;
               end else begin
                  ram_valid = 1'b0; rcnt++;
               end
            end else begin
               ram_valid = 1'b0; rcnt = 0;
            end
         end
         alu_zero = (az_force == 1) ? 1'b1 : (az_force == 2) ? 1'b0 : ^alu_op;
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (mon_on && rst_n && (write_en || flags[23])) obs_q.push_back({write_en, flags});
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n  = 1'b0;
      run_en = 1'b0;
      @(posedge clk); #1;
      rst_n  = 1'b1;
      run_en = 1'b1;
   endtask

   task automatic wait_halt(input int max);
      for (int c = 0; c < max && !halted; c++) begin
         @(posedge clk); #1;
         if (rnd_run) run_en = ($urandom_range(0, 3) != 0);
      end
      check("halt_timeout", 32'(halted), 32'd1);
   endtask

   function automatic int unsigned out_bit(input int unsigned s);
      if (s < 8) return 12 + s;
      if (s == 8) return 21;
      if (s == 9) return 22;
      return 24;
   endfunction

   function automatic logic [24:0] fmask(input int unsigned d, input int unsigned s);
      logic [24:0] m;
      m = '0;
      m[d] = 1'b1;
      m[out_bit(s)] = 1'b1;
      return m;
   endfunction

   function automatic logic [15:0] mk(input int unsigned o, d, s, a);
      return {o[3:0], d[3:0], s[3:0], a[3:0]};
   endfunction

   // Build a random program while interpreting it at instruction level
   task automatic random_run(input int n);
      int unsigned a, target, d, s, k, ao, r, exp_pc, cnt;
      bit z;
      a = 0; z = 1'b0;
      clear_mem();
      exp_q.delete();
      obs_q.delete();
      for (int i = 0; i < n; i++) begin
         r = $urandom_range(0, 7);
         d = $urandom_range(0, 11);
         s = $urandom_range(0, 10);
         ao = $urandom_range(0, 15);
         k = $urandom_range(0, 2);
         case (r)
            1: begin
               mem[a] = mk(1, d, s, ao);
               exp_q.push_back({1'b1, fmask(d, s)});
               if (s == 8) begin mem[a+1] = 16'($urandom); a += 2; end
               else a += 1;
            end
            2: begin
               d = d % 8; s = s % 8;
               mem[a] = mk(2, d, s, ao);
               exp_q.push_back({1'b1, fmask(d, s) | 25'h100000});
               z = ^ao[3:0];
               a += 1;
            end
            3: begin
               mem[a] = mk(3, d, 0, 0);
               mem[a+1] = 16'($urandom);
               exp_q.push_back({1'b1, fmask(d, 8)});
               a += 2;
            end
            4, 5: begin
               target = a + 2 + k;
               mem[a] = mk(r, 0, 0, 0);
               mem[a+1] = 16'(target);
               if (r == 4 || z) begin
                  exp_q.push_back({1'b0, 25'h800000});
                  for (int unsigned j = a + 2; j < target; j++) mem[j] = 16'h7000;
                  a = target;
               end else begin
                  a += 2;
               end
            end
            6: begin
               mem[a] = mk(6, 0, s, 0);
               exp_q.push_back({1'b1, fmask(11, s)});
               if (s == 8) begin mem[a+1] = 16'($urandom); a += 2; end
               else a += 1;
            end
            default: begin
               mem[a] = 16'h0000;
               a += 1;
            end
         endcase
      end
      mem[a] = 16'hF000;
      exp_pc = a + 1;
      lat_min = 0; lat_max = 3; rlat_min = 0; rlat_max = 3;
      az_force = 0;
      do_reset();
      mon_on = 1'b1;
      rnd_run = 1'b1;
      wait_halt(20000);
      rnd_run = 1'b0;
      @(negedge clk);
      mon_on = 1'b0;
      check("rnd_pc", 32'(pc), exp_pc);
      check("rnd_illegal", 32'(illegal), 32'd0);
      check("rnd_events", obs_q.size(), exp_q.size());
      cnt = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < int'(cnt); i++) check("rnd_event", 32'(obs_q[i]), 32'(exp_q[i]));
      lat_max = 0; rlat_max = 0;
   endtask

   initial begin : main
      clear_mem();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_flags", 32'(flags), 32'd0);
      check("rst_we", 32'(write_en), 32'd0);
      check("rst_req", 32'(rom_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);

      // MOV A <- B
      mem[0] = 16'h1010;
      do_reset();
      tick(1);
      check("mov_req", 32'(rom_req), 32'd1);
      check("mov_addr", 32'(rom_addr), 32'd0);
      tick(1);
      check("mov_dec_pc", 32'(pc), 32'd1);
      check("mov_dec_flags", 32'(flags), 32'd0);
      tick(1);
      check("mov_flags", 32'(flags), 32'h002001);
      check("mov_we", 32'(write_en), 32'd1);
      check("mov_pc", 32'(pc), 32'd1);
      tick(1);
      check("mov_after_flags", 32'(flags), 32'd0);
      check("mov_after_we", 32'(write_en), 32'd0);

      // LDI C, 0x1234
      clear_mem();
      mem[0] = 16'h3280; mem[1] = 16'h1234;
      do_reset();
      tick(3);
      check("ldi_imm_req", 32'(rom_req), 32'd1);
      check("ldi_imm_addr", 32'(rom_addr), 32'd1);
      tick(1);
      check("ldi_flags", 32'(flags), 32'h200004);
      check("ldi_we", 32'(write_en), 32'd1);
      check("ldi_pc", 32'(pc), 32'd2);
      tick(1);
      check("ldi_after_we", 32'(write_en), 32'd0);

      // ALU A,B op5 then JZ 0x0040, taken and not taken
      for (int t = 0; t < 2; t++) begin
         clear_mem();
         mem[0] = 16'h2015; mem[1] = 16'h5000; mem[2] = 16'h0040;
         mem[3] = 16'hF000; mem[16'h40] = 16'hF000;
         az_force = (t == 0) ? 1 : 2;
         do_reset();
         tick(3);
         check("alu_flags", 32'(flags), 32'h102001);
         check("alu_we", 32'(write_en), 32'd1);
         check("alu_op", 32'(alu_op), 32'd5);
         tick(4);
         check("jz_pc", 32'(pc), (t == 0) ? 32'h40 : 32'd3);
         check("jz_flags", 32'(flags), (t == 0) ? 32'h800000 : 32'd0);
         check("jz_we", 32'(write_en), 32'd0);
         wait_halt(100);
         check("jz_halt_pc", 32'(pc), (t == 0) ? 32'h41 : 32'd4);
      end
      az_force = 0;

      // ROM withheld 5 cycles in FETCH and in IMM
      clear_mem();
      mem[0] = 16'h3280; mem[1] = 16'h1234;
      lat_min = 5; lat_max = 5;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("fhold_req", 32'(rom_req), 32'd1);
         check("fhold_flags", 32'(flags), 32'd0);
         check("fhold_pc", 32'(pc), 32'd0);
      end
      tick(2);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("ihold_req", 32'(rom_req), 32'd1);
         check("ihold_addr", 32'(rom_addr), 32'd1);
         check("ihold_flags", 32'(flags), 32'd0);
         check("ihold_pc", 32'(pc), 32'd1);
      end
      tick(2);
      check("ihold_wflags", 32'(flags), 32'h200004);
      check("ihold_pc2", 32'(pc), 32'd2);
      lat_min = 0; lat_max = 0;

      // MOV A <- RAM with ram_valid held off 3 cycles
      clear_mem();
      mem[0] = 16'h1090;
      rlat_min = 3; rlat_max = 3;
      do_reset();
      tick(2);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("ram_hold_flags", 32'(flags), 32'h400001);
         check("ram_hold_we", 32'(write_en), 32'd0);
      end
      tick(1);
      check("ram_flags", 32'(flags), 32'h400001);
      check("ram_we", 32'(write_en), 32'd1);
      tick(1);
      check("ram_after_flags", 32'(flags), 32'd0);
      rlat_min = 0; rlat_max = 0;

      // Illegal opcode, then single-edge reset
      clear_mem();
      mem[0] = 16'h7000;
      do_reset();
      tick(3);
      check("ill_illegal", 32'(illegal), 32'd1);
      check("ill_halted", 32'(halted), 32'd1);
      check("ill_flags", 32'(flags), 32'd0);
      check("ill_req", 32'(rom_req), 32'd0);
      tick(3);
      check("ill_stay", 32'(halted), 32'd1);
      check("ill_stay_pc", 32'(pc), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0; run_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick(1);
      check("ill_rst_illegal", 32'(illegal), 32'd0);
      check("ill_rst_halted", 32'(halted), 32'd0);
      check("ill_rst_pc", 32'(pc), 32'd0);

      // ALU with dst field out of range
      mem[0] = 16'h2900;
      do_reset();
      tick(3);
      check("ill_field", 32'(illegal), 32'd1);

      // pc wrap from 0xFFFF
      clear_mem();
      mem[0] = 16'h4000; mem[1] = 16'hFFFF; mem[16'hFFFF] = 16'h0000;
      do_reset();
      tick(4);
      check("wrap_jmp_pc", 32'(pc), 32'hFFFF);
      check("wrap_jmpo", 32'(flags), 32'h800000);
      tick(1);
      check("wrap_addr", 32'(rom_addr), 32'hFFFF);
      tick(1);
      check("wrap_pc", 32'(pc), 32'd0);

      for (int r = 0; r < 3; r++) random_run(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
